wb_commit_queue: RTL

//  Write side of the register file: buffers results from the execute/memory stages and drains them in order,
//  one per cycle, onto the register file write port (write_enable/write_address/write_value).

---
 rtl/wb_commit_queue.sv | 112 +++++++++++
 1 files changed

// File: rtl/wb_commit_queue.sv
// rtl/wb_commit_queue.sv - in-order register writeback queue with youngest-first operand lookup
module wb_commit_queue #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_addr,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      wb_stall,
   output logic                      write_enable,
   output logic [ADDR_W-1:0]         write_address,
   output logic [DATA_W-1:0]         write_value,
   input  logic [ADDR_W-1:0]         rs1_addr,
   output logic                      rs1_hit,
   output logic [DATA_W-1:0]         rs1_data,
   input  logic [ADDR_W-1:0]         rs2_addr,
   output logic                      rs2_hit,
   output logic [DATA_W-1:0]         rs2_data,
   output logic [$clog2(DEPTH):0]    q_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]  r_valid;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;
   logic              r_we;
   logic [ADDR_W-1:0] r_wa;
   logic [DATA_W-1:0] r_wv;

   logic              w_enq;
   logic              w_deq;
   logic [PTR_W-1:0]  w_idx;

   assign in_ready      = (r_count < CNT_W'(DEPTH));
   // x0 writes complete the handshake but never occupy an entry
   assign w_enq         = in_valid && in_ready && (in_addr != '0);
   assign w_deq         = (r_count != '0) && !wb_stall;
   assign write_enable  = r_we;
   assign write_address = r_wa;
   assign write_value   = r_wv;
   assign q_count       = r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         r_we    <= 1'b0;
         r_wa    <= '0;
         r_wv    <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_valid <= '0;
         r_we    <= 1'b0;
      end else begin
         if (w_enq) begin
            r_addr[r_tail]  <= in_addr;
            r_data[r_tail]  <= in_data;
            r_valid[r_tail] <= 1'b1;
            r_tail          <= r_tail + PTR_W'(1);
         end
         if (w_deq) begin
            r_wa            <= r_addr[r_head];
            r_wv            <= r_data[r_head];
            r_we            <= 1'b1;
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + PTR_W'(1);
         end else begin
            r_we <= 1'b0;
         end
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Walk oldest to youngest so the last match wins, giving youngest-first priority
   always_comb begin
      rs1_hit  = 1'b0;
      rs1_data = '0;
      rs2_hit  = 1'b0;
      rs2_data = '0;
      w_idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_idx = r_head + PTR_W'(i);
         if (r_valid[w_idx] && (rs1_addr != '0) && (r_addr[w_idx] == rs1_addr)) begin
            rs1_hit  = 1'b1;
            rs1_data = r_data[w_idx];
         end
         if (r_valid[w_idx] && (rs2_addr != '0) && (r_addr[w_idx] == rs2_addr)) begin
            rs2_hit  = 1'b1;
            rs2_data = r_data[w_idx];
         end
      end
   end

endmodule
